bus_dispatch_scheduler: RTL and testbench
=========================================

# bus_dispatch_scheduler

Sequences the shuttle bus between its two boarding stations. Accumulates passenger requests per station, picks which station the bus serves next on each scheduler tick, and hands the job to the bus motion/fare controller over a valid/ready grant handshake. Sits between the PS/2 key decoder, which supplies request pulses, and the bus state machine, which consumes grants and reports completion.

## Interface
- `MAX_WAIT`, 2: per-station waiting-count ceiling.
- `FARE_B1`, 30: fare per passenger boarding at station B1.
- `FARE_B2`, 20: fare per passenger boarding at station B2.
- `POS_B1`, 0: bus position index of station B1.
- `POS_B2`, 6: bus position index of station B2.
- `AGE_LIMIT`, 3: consecutive losses before a station is promoted (aging builds only).

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle scheduling strobe from the divider.
- `req`  in  2  one-cycle arrival pulses; bit 0 = B1, bit 1 = B2.
- `bus_pos`  in  3  current bus position.
- `bus_done`  in  1  one-cycle pulse: the current job has finished.
- `grant_valid`  out  1  job offered.
- `grant_ready`  in  1  bus controller accepts the job.
- `grant_station`  out  1  0 = B1, 1 = B2.
- `grant_count`  out  2  passengers boarding.
- `grant_fare`  out  8  `grant_count` × station fare.
- `wait_b1`, `wait_b2`  out  2  live waiting counts (drive the LEDs).
- `drop`  out  1  one-cycle pulse when a request hits a full station.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- Counters: `req[i]` increments count i when count i < `MAX_WAIT`. Otherwise the count holds and `drop` pulses. Both bits may fire in the same cycle; both are handled.
- States: IDLE, DECIDE, OFFER, BUSY.
- IDLE → DECIDE on `tick` when any count > 0. A tick with no waiting passengers is ignored.
- DECIDE, one cycle, registers the winner:
  - Exactly one station nonzero: that station wins.
  - Both nonzero: the station whose position equals `bus_pos` wins.
  - Otherwise: the station not in `last_served` wins.
  - The winner's count is snapshotted into `grant_count`, and `grant_fare` is registered. Then → OFFER.
- OFFER: `grant_valid` = 1 and the payload is held stable until `grant_valid && grant_ready`.
  - On that handshake: count(winner) ← count − snapshot + (same-cycle req for that station), saturating at `MAX_WAIT`.
  - `last_served` ← winner, then → BUSY.
- BUSY → IDLE on `bus_done`. In every other state, `bus_done` is ignored.
- Requests are accepted in every state. Arrivals after the snapshot stay pending for a later job.
- Ticks outside IDLE are ignored; there is no queuing of ticks.

## Timing
- Reset values: all outputs 0, state IDLE. `last_served` = B2, so B1 wins the first round-robin tie.
- `req` pulse to updated `wait_bX`: 1 cycle (registered).
- `tick` at cycle N (IDLE) → `grant_valid` high at N+2.
- `grant_ready` held high in OFFER: `grant_valid` drops on the next cycle, state is BUSY, and the count is updated on that same edge.
- `grant_ready` before `grant_valid` has no effect.
- `drop` lasts exactly one cycle per rejected pulse.
- Asserting reset mid-OFFER or mid-BUSY immediately clears counts, grant, and state. No job is replayed.
- Fare width is 8 bits; the maximum is 2 × 30 = 60, so no overflow.

## Configuration
- `BUS_SCHED_AGING_EN` defined:
  - Each station has a 2-bit age counter. It increments when that station was nonzero in DECIDE but lost, and clears when the station wins.
  - A station with age ≥ `AGE_LIMIT` wins over the position rule. If both stations are aged, round-robin decides.
- Macro undefined: no age registers; the arbitration is exactly as in Operation.

## Structure
- Package `bus_sched_pkg` holds:
  - the state encoding (IDLE/DECIDE/OFFER/BUSY);
  - station ids `ST_B1 = 0` and `ST_B2 = 1`;
  - default fares and positions;
  - the count width.
- Sub-module `station_wait_counter`, instantiated twice, provides saturating increment, a snapshot-subtract on clear, and the `drop` flag.
- The arbitration logic and the FSM stay in the top module.

## Test plan
- Three B1 pulses, then a tick with `bus_pos` = 3 → `wait_b1` = 2, one `drop` pulse; grant: station 0, count 2, fare 60, `grant_valid` at tick + 2.
- B1 = 1 and B2 = 2, tick with `bus_pos` = 6 → station 1, count 2, fare 40; `wait_b1` stays 1.
- Both stations = 1, `bus_pos` = 3, two full grant/done cycles → B1 served first, then B2.
- In OFFER with snapshot 2, a B1 req in the same cycle as the handshake → `wait_b1` = 1 afterwards.
- `grant_ready` held low for 10 cycles, then raised → payload unchanged throughout; a single handshake occurs.
- Reset asserted during BUSY → all outputs 0 in the same cycle; a later tick with no requests produces no grant. With `BUS_SCHED_AGING_EN`: B1 kept nonzero while losing 3 times to a position-matched B2 → B1 wins the 4th decision.

Source files
------------

// File: rtl/bus_sched_pkg.sv
// Shared types and defaults for the shuttle bus dispatch scheduler.
// Optional aging arbitration is enabled with BUS_SCHED_AGING_EN.
package bus_sched_pkg;

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECIDE = 2'd1,
    S_OFFER  = 2'd2,
    S_BUSY   = 2'd3
  } state_t;

  localparam logic ST_B1 = 1'b0;
  localparam logic ST_B2 = 1'b1;

  localparam int DEF_MAX_WAIT  = 2;
  localparam int DEF_FARE_B1   = 30;
  localparam int DEF_FARE_B2   = 20;
  localparam int DEF_POS_B1    = 0;
  localparam int DEF_POS_B2    = 6;
  localparam int DEF_AGE_LIMIT = 3;

  function automatic logic [7:0] calc_fare(input logic [CNT_W-1:0] cnt,
                                           input logic [7:0]       fare);
    return 8'({6'd0, cnt} * fare);
  endfunction

endpackage

// File: rtl/station_wait_counter.sv
// Per-station waiting-passenger counter: saturating increment, snapshot
// subtraction when a job is accepted, and a one-cycle drop flag.
module station_wait_counter
  import bus_sched_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_snap,
  output logic [CNT_W-1:0] o_count,
  output logic             o_drop
);

  logic [CNT_W-1:0] r_count;
  logic             r_drop;
  logic [CNT_W-1:0] w_base;
  logic [CNT_W-1:0] w_next;
  logic             w_drop;

  // A same-cycle arrival lands on top of what is left after the snapshot.
  always_comb begin
    w_base = i_clr ? (r_count - i_snap) : r_count;
    w_next = w_base;
    w_drop = 1'b0;
    if (i_req) begin
      if (w_base < CNT_W'(MAX_WAIT)) w_next = w_base + 1'b1;
      else                           w_drop = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_count <= w_next;
      r_drop  <= w_drop;
    end
  end

  assign o_count = r_count;
  assign o_drop  = r_drop;

endmodule

// File: rtl/bus_dispatch_scheduler.sv
// Picks the next boarding station for the shuttle and offers it over valid/ready.
// Define BUS_SCHED_AGING_EN to promote a station that keeps losing arbitration.
module bus_dispatch_scheduler
  import bus_sched_pkg::*;
#(
  parameter int MAX_WAIT  = DEF_MAX_WAIT,
  parameter int FARE_B1   = DEF_FARE_B1,
  parameter int FARE_B2   = DEF_FARE_B2,
  parameter int POS_B1    = DEF_POS_B1,
  parameter int POS_B2    = DEF_POS_B2
`ifdef BUS_SCHED_AGING_EN
  , parameter int AGE_LIMIT = DEF_AGE_LIMIT
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] req,
  input  logic [2:0] bus_pos,
  input  logic       bus_done,
  output logic       grant_valid,
  input  logic       grant_ready,
  output logic       grant_station,
  output logic [1:0] grant_count,
  output logic [7:0] grant_fare,
  output logic [1:0] wait_b1,
  output logic [1:0] wait_b2,
  output logic       drop,
  output logic       busy
);

  state_t           r_state, w_next_state;
  logic             r_last;
  logic             r_gnt_station;
  logic [CNT_W-1:0] r_gnt_count;
  logic [7:0]       r_gnt_fare;
  logic [CNT_W-1:0] w_cnt1, w_cnt2;
  logic             w_drop1, w_drop2;
  logic             w_nz1, w_nz2;
  logic             w_hs;
  logic             w_win;
  logic             w_pos_win;
  logic [CNT_W-1:0] w_win_cnt;

  assign w_hs = (r_state == S_OFFER) && grant_ready;

  station_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_cnt_b1 (
    .clk(clk), .rst(rst), .i_req(req[0]),
    .i_clr(w_hs && (r_gnt_station == ST_B1)), .i_snap(r_gnt_count),
    .o_count(w_cnt1), .o_drop(w_drop1)
  );

  station_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_cnt_b2 (
    .clk(clk), .rst(rst), .i_req(req[1]),
    .i_clr(w_hs && (r_gnt_station == ST_B2)), .i_snap(r_gnt_count),
    .o_count(w_cnt2), .o_drop(w_drop2)
  );

  assign w_nz1 = |w_cnt1;
  assign w_nz2 = |w_cnt2;

  always_comb begin
    w_pos_win = ~r_last;
    if (bus_pos == 3'(POS_B1))      w_pos_win = ST_B1;
    else if (bus_pos == 3'(POS_B2)) w_pos_win = ST_B2;
  end

`ifdef BUS_SCHED_AGING_EN
  logic [1:0] r_age1, r_age2;
  logic       w_aged1, w_aged2;
  assign w_aged1 = ({30'd0, r_age1} >= AGE_LIMIT);
  assign w_aged2 = ({30'd0, r_age2} >= AGE_LIMIT);

  // An aged station overrides the position rule; two aged stations fall back to round-robin.
  always_comb begin
    w_win = w_pos_win;
    if (w_nz1 && !w_nz2)           w_win = ST_B1;
    else if (w_nz2 && !w_nz1)      w_win = ST_B2;
    else if (w_aged1 && !w_aged2)  w_win = ST_B1;
    else if (w_aged2 && !w_aged1)  w_win = ST_B2;
    else if (w_aged1 && w_aged2)   w_win = ~r_last;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_age1 <= '0;
      r_age2 <= '0;
    end else if (r_state == S_DECIDE) begin
      if (w_win == ST_B1) begin
        r_age1 <= '0;
        if (w_nz2 && r_age2 != 2'd3) r_age2 <= r_age2 + 1'b1;
      end else begin
        r_age2 <= '0;
        if (w_nz1 && r_age1 != 2'd3) r_age1 <= r_age1 + 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_win = w_pos_win;
    if (w_nz1 && !w_nz2)      w_win = ST_B1;
    else if (w_nz2 && !w_nz1) w_win = ST_B2;
  end
`endif

  assign w_win_cnt = (w_win == ST_B2) ? w_cnt2 : w_cnt1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (tick && (w_nz1 || w_nz2)) w_next_state = S_DECIDE;
      S_DECIDE: w_next_state = S_OFFER;
      S_OFFER:  if (grant_ready) w_next_state = S_BUSY;
      S_BUSY:   if (bus_done) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    grant_valid = 1'b0;
    busy        = 1'b0;
    if (r_state == S_OFFER) grant_valid = 1'b1;
    if (r_state != S_IDLE)  busy        = 1'b1;
  end

  // Payload is captured once in DECIDE and held untouched through OFFER.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt_station <= 1'b0;
      r_gnt_count   <= '0;
      r_gnt_fare    <= '0;
      r_last        <= ST_B2;
    end else begin
      if (r_state == S_DECIDE) begin
        r_gnt_station <= w_win;
        r_gnt_count   <= w_win_cnt;
        r_gnt_fare    <= calc_fare(w_win_cnt, (w_win == ST_B2) ? 8'(FARE_B2) : 8'(FARE_B1));
      end
      if (w_hs) r_last <= r_gnt_station;
    end
  end

  assign grant_station = r_gnt_station;
  assign grant_count   = r_gnt_count;
  assign grant_fare    = r_gnt_fare;
  assign wait_b1       = w_cnt1;
  assign wait_b2       = w_cnt2;
  assign drop          = w_drop1 | w_drop2;

endmodule

// File: tb/tb_bus_dispatch_scheduler.sv
// Bench for bus_dispatch_scheduler: directed test-plan steps plus random traffic
// against a transaction-level model of the scheduling rules.
module tb_bus_dispatch_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [1:0] req;
  logic [2:0] bus_pos;
  logic       bus_done;
  logic       grant_valid;
  logic       grant_ready;
  logic       grant_station;
  logic [1:0] grant_count;
  logic [7:0] grant_fare;
  logic [1:0] wait_b1, wait_b2;
  logic       drop;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: counts, scheduler phase (0 idle,1 decide,2 offer,3 busy), payload.
  int m_cnt[2];
  int m_age[2];
  int m_ph, m_win, m_snap, m_fare, m_last;
  bit m_drop;

  bus_dispatch_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .req(req), .bus_pos(bus_pos),
    .bus_done(bus_done), .grant_valid(grant_valid), .grant_ready(grant_ready),
    .grant_station(grant_station), .grant_count(grant_count), .grant_fare(grant_fare),
    .wait_b1(wait_b1), .wait_b2(wait_b2), .drop(drop), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_cnt[0] = 0; m_cnt[1] = 0; m_age[0] = 0; m_age[1] = 0;
    m_ph = 0; m_win = 0; m_snap = 0; m_fare = 0; m_last = 1; m_drop = 0;
  endtask

  function automatic int pick(input int pos);
    if (m_cnt[0] > 0 && m_cnt[1] == 0) return 0;
    if (m_cnt[1] > 0 && m_cnt[0] == 0) return 1;
`ifdef BUS_SCHED_AGING_EN
    if (m_age[0] >= 3 && m_age[1] < 3) return 0;
    if (m_age[1] >= 3 && m_age[0] < 3) return 1;
    if (m_age[0] >= 3 && m_age[1] >= 3) return 1 - m_last;
`endif
    if (pos == 0) return 0;
    if (pos == 6) return 1;
    return 1 - m_last;
  endfunction

  task automatic model_step(input logic [1:0] r, input logic t, input logic g,
                            input logic d, input int pos);
    int nc[2];
    int base;
    int w;
    bit hs;
    hs = (m_ph == 2) && g;
    m_drop = 0;
    for (int i = 0; i < 2; i++) begin
      base = m_cnt[i] - ((hs && m_win == i) ? m_snap : 0);
      if (r[i]) begin
        if (base < 2) base++;
        else m_drop = 1;
      end
      nc[i] = base;
    end
    case (m_ph)
      0: if (t && (m_cnt[0] > 0 || m_cnt[1] > 0)) m_ph = 1;
      1: begin
        w = pick(pos);
        if (m_cnt[1 - w] > 0 && m_age[1 - w] < 3) m_age[1 - w]++;
        m_age[w] = 0;
        m_win  = w;
        m_snap = m_cnt[w];
        m_fare = m_snap * (w == 1 ? 20 : 30);
        m_ph   = 2;
      end
      2: if (g) begin m_last = m_win; m_ph = 3; end
      default: if (d) m_ph = 0;
    endcase
    m_cnt[0] = nc[0];
    m_cnt[1] = nc[1];
  endtask

  task automatic check_all();
    chk("wait_b1", wait_b1, m_cnt[0]);
    chk("wait_b2", wait_b2, m_cnt[1]);
    chk("drop", drop, m_drop);
    chk("grant_valid", grant_valid, (m_ph == 2));
    chk("busy", busy, (m_ph != 0));
    chk("grant_station", grant_station, m_win);
    chk("grant_count", grant_count, m_snap);
    chk("grant_fare", grant_fare, m_fare);
  endtask

  task automatic cyc(input logic [1:0] r, input logic t, input logic g, input logic d);
    req = r; tick = t; grant_ready = g; bus_done = d;
    model_step(r, t, g, d, int'(bus_pos));
    @(posedge clk); #1;
    req = '0; tick = 1'b0; grant_ready = 1'b0; bus_done = 1'b0;
    check_all();
  endtask

  task automatic full_job(input logic [1:0] r_at_hs);
    cyc(2'b00, 1'b1, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0, 1'b0);
    chk("job_valid", grant_valid, 1);
    cyc(r_at_hs, 1'b0, 1'b1, 1'b0);
    cyc(2'b00, 1'b0, 1'b0, 1'b1);
  endtask

  int st_seen;

  initial begin
    rst = 1'b0; tick = 1'b0; req = '0; bus_pos = 3'd3; bus_done = 1'b0; grant_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_last_tie_b1", grant_station, 0);
    rst = 1'b1;

    // Saturation and drop, then a 2-passenger B1 job held in OFFER for 10 cycles.
    cyc(2'b00, 1'b0, 1'b1, 1'b0);
    cyc(2'b01, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 1'b0, 1'b0);
    chk("tp1_no_drop", drop, 0);
    cyc(2'b01, 1'b0, 1'b0, 1'b0);
    chk("tp1_drop", drop, 1);
    chk("tp1_wait", wait_b1, 2);
    cyc(2'b00, 1'b0, 1'b0, 1'b0);
    chk("tp1_drop_one_cycle", drop, 0);
    cyc(2'b00, 1'b1, 1'b0, 1'b0);
    chk("tp1_valid_n1", grant_valid, 0);
    cyc(2'b00, 1'b0, 1'b0, 1'b0);
    chk("tp1_valid_n2", grant_valid, 1);
    chk("tp1_station", grant_station, 0);
    chk("tp1_count", grant_count, 2);
    chk("tp1_fare", grant_fare, 60);
    for (int i = 0; i < 10; i++) begin
      cyc(2'b00, (i == 3), 1'b0, 1'b0);
      chk("hold_valid", grant_valid, 1);
      chk("hold_fare", grant_fare, 60);
    end
    cyc(2'b00, 1'b0, 1'b1, 1'b0);
    chk("hs_valid_drop", grant_valid, 0);
    chk("hs_busy", busy, 1);
    chk("hs_wait_b1", wait_b1, 0);
    cyc(2'b00, 1'b0, 1'b1, 1'b0);
    cyc(2'b00, 1'b0, 1'b0, 1'b1);
    chk("done_idle", busy, 0);

    // Position match picks B2.
    cyc(2'b01, 1'b0, 1'b0, 1'b0);
    cyc(2'b10, 1'b0, 1'b0, 1'b0);
    cyc(2'b10, 1'b0, 1'b0, 1'b0);
    bus_pos = 3'd6;
    cyc(2'b00, 1'b1, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0, 1'b0);
    chk("tp2_station", grant_station, 1);
    chk("tp2_count", grant_count, 2);
    chk("tp2_fare", grant_fare, 40);
    cyc(2'b00, 1'b0, 1'b1, 1'b0);
    chk("tp2_wait_b1", wait_b1, 1);
    chk("tp2_wait_b2", wait_b2, 0);
    cyc(2'b00, 1'b0, 1'b0, 1'b1);

    // Round-robin tie with no position match: B1, then B2.
    cyc(2'b10, 1'b0, 1'b0, 1'b0);
    bus_pos = 3'd3;
    cyc(2'b00, 1'b1, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0, 1'b0);
    chk("rr_first", grant_station, 0);
    cyc(2'b00, 1'b0, 1'b1, 1'b0);
    cyc(2'b00, 1'b0, 1'b0, 1'b1);
    cyc(2'b00, 1'b1, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0, 1'b0);
    chk("rr_second", grant_station, 1);
    cyc(2'b00, 1'b0, 1'b1, 1'b0);
    cyc(2'b00, 1'b0, 1'b0, 1'b1);

    // Arrival in the handshake cycle stays pending.
    cyc(2'b01, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 1'b0, 1'b0);
    full_job(2'b01);
    chk("snap_pending", wait_b1, 1);

    // Reset during BUSY clears everything at once.
    cyc(2'b10, 1'b0, 1'b0, 1'b0);
    cyc(2'b00, 1'b1, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", busy, 0);
    chk("rst_valid", grant_valid, 0);
    chk("rst_wait_b1", wait_b1, 0);
    chk("rst_wait_b2", wait_b2, 0);
    chk("rst_fare", grant_fare, 0);
    chk("rst_count", grant_count, 0);
    #2 rst = 1'b1;
    cyc(2'b00, 1'b1, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0, 1'b0);
    chk("empty_tick_valid", grant_valid, 0);
    chk("empty_tick_busy", busy, 0);

    // B1 keeps losing to a position-matched B2.
    bus_pos = 3'd6;
    for (int k = 0; k < 4; k++) begin
      cyc(2'b11, 1'b0, 1'b0, 1'b0);
      cyc(2'b00, 1'b1, 1'b0, 1'b0);
      cyc(2'b00, 1'b0, 1'b0, 1'b0);
      st_seen = int'(grant_station);
      cyc(2'b00, 1'b0, 1'b1, 1'b0);
      cyc(2'b00, 1'b0, 1'b0, 1'b1);
    end
`ifdef BUS_SCHED_AGING_EN
    chk("aging_4th", st_seen, 0);
`else
    chk("aging_4th", st_seen, 1);
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: bus_pos = 3'd0;
        1: bus_pos = 3'd6;
        default: bus_pos = 3'($urandom_range(0, 7));
      endcase
      cyc(2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
